// File: rtl/mdu_pkg.sv
// Shared MDU types, counter width and default latencies for the HI/LO sequencer.
// The madd-family decode is only present when MDU_MADD_EN is defined.
package mdu_pkg;

    localparam int MD_CNT_W         = 4;
    localparam int MULT_CYCLES_DEF  = 5;
    localparam int DIV_CYCLES_DEF   = 10;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8,
        MD_MSUB  = 4'd9,
        MD_MSUBU = 4'd10
    } md_op_t;

    function automatic logic is_mul_op(input logic [3:0] op);
        logic r;
        case (op)
            MD_MULT, MD_MULTU: r = 1'b1;
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        logic r;
        case (op)
            MD_DIV, MD_DIVU: r = 1'b1;
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational MDU datapath: product, quotient/remainder and optional accumulate.
// Accumulate ops (MADD/MADDU/MSUB/MSUBU) are built only when MDU_MADD_EN is defined.
module md_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    output logic [63:0] o_res,
    output logic        o_div0
);

    logic [63:0] w_sprod;
    logic [63:0] w_uprod;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_sdvs;
    logic [31:0] w_udvs;
    logic [31:0] w_sq_mag;
    logic [31:0] w_sr_mag;
    logic [31:0] w_squo;
    logic [31:0] w_srem;
    logic        w_b_zero;

    assign w_sprod  = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    assign w_uprod  = {32'd0, i_a} * {32'd0, i_b};
    assign w_b_zero = (i_b == 32'd0);

    // Signed divide via magnitudes so the most-negative dividend never overflows.
    assign w_mag_a  = i_a[31] ? (32'd0 - i_a) : i_a;
    assign w_mag_b  = i_b[31] ? (32'd0 - i_b) : i_b;
    assign w_sdvs   = w_b_zero ? 32'd1 : w_mag_b;
    assign w_udvs   = w_b_zero ? 32'd1 : i_b;
    assign w_sq_mag = w_mag_a / w_sdvs;
    assign w_sr_mag = w_mag_a % w_sdvs;
    assign w_squo   = (i_a[31] ^ i_b[31]) ? (32'd0 - w_sq_mag) : w_sq_mag;
    assign w_srem   = i_a[31] ? (32'd0 - w_sr_mag) : w_sr_mag;

    // Opcode select; anything not producing a result returns current HI/LO.
    always_comb begin
        o_res  = {i_hi, i_lo};
        o_div0 = 1'b0;
        case (i_op)
            MD_MULT:  o_res = w_sprod;
            MD_MULTU: o_res = w_uprod;
            MD_DIV: begin
                if (w_b_zero) begin
                    o_div0 = 1'b1;
                end else begin
                    o_res = {w_srem, w_squo};
                end
            end
            MD_DIVU: begin
                if (w_b_zero) begin
                    o_div0 = 1'b1;
                end else begin
                    o_res = {i_a % w_udvs, i_a / w_udvs};
                end
            end
`ifdef MDU_MADD_EN
            MD_MADD:  o_res = {i_hi, i_lo} + w_sprod;
            MD_MADDU: o_res = {i_hi, i_lo} + w_uprod;
            MD_MSUB:  o_res = {i_hi, i_lo} - w_sprod;
            MD_MSUBU: o_res = {i_hi, i_lo} - w_uprod;
`endif
            default:  o_res = {i_hi, i_lo};
        endcase
    end

endmodule

// File: rtl/md_scheduler.sv
// HI/LO sequencer: fixed-latency busy countdown, commit on 1->0, stall request to hazard logic.
// MDU_MADD_EN enables the madd-family opcodes (decoded in mdu_pkg, computed in md_arith).
module md_scheduler
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  e_md_op,
    input  logic [31:0] e_src_a,
    input  logic [31:0] e_src_b,
    input  logic        d_md_use,
    output logic        start,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [MD_CNT_W-1:0] r_cnt;
    logic                r_busy;
    logic [31:0]         r_hi;
    logic [31:0]         r_lo;
    logic [31:0]         r_res_hi;
    logic [31:0]         r_res_lo;
    logic                r_skip;
    logic [63:0]         w_res;
    logic                w_div0;
    logic                w_is_mul;
    logic                w_is_div;
    logic                w_idle;
    logic                w_start;

    md_arith u_arith (
        .i_op   (e_md_op),
        .i_a    (e_src_a),
        .i_b    (e_src_b),
        .i_hi   (r_hi),
        .i_lo   (r_lo),
        .o_res  (w_res),
        .o_div0 (w_div0)
    );

    assign w_is_mul  = is_mul_op(e_md_op);
    assign w_is_div  = is_div_op(e_md_op);
    assign w_idle    = (r_cnt == {MD_CNT_W{1'b0}});
    assign w_start   = (w_is_mul | w_is_div) & w_idle;
    assign start     = w_start;
    assign stall_req = d_md_use & (w_start | r_busy);
    assign busy      = r_busy;
    assign hi        = r_hi;
    assign lo        = r_lo;

    // Countdown, result latch and HI/LO commit; a divide by zero keeps HI/LO untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= {MD_CNT_W{1'b0}};
            r_busy   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_res_hi <= 32'd0;
            r_res_lo <= 32'd0;
            r_skip   <= 1'b0;
        end else if (w_start) begin
            r_res_hi <= w_res[63:32];
            r_res_lo <= w_res[31:0];
            r_skip   <= w_div0;
            r_cnt    <= w_is_div ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);
            r_busy   <= 1'b1;
        end else if (!w_idle) begin
            r_cnt  <= r_cnt - {{(MD_CNT_W-1){1'b0}}, 1'b1};
            r_busy <= (r_cnt != {{(MD_CNT_W-1){1'b0}}, 1'b1});
            if ((r_cnt == {{(MD_CNT_W-1){1'b0}}, 1'b1}) && !r_skip) begin
                r_hi <= r_res_hi;
                r_lo <= r_res_lo;
            end else begin
                r_hi <= r_hi;
                r_lo <= r_lo;
            end
        end else begin
            case (e_md_op)
                MD_MTHI: r_hi <= e_src_a;
                MD_MTLO: r_lo <= e_src_a;
                default: r_hi <= r_hi;
            endcase
        end
    end

endmodule

// File: tb/tb_md_scheduler.sv
// Scoreboard bench for md_scheduler: expected HI/LO pushed at issue, popped at commit.
// Builds with or without MDU_MADD_EN.
module tb_md_scheduler;
    import mdu_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [3:0]  e_md_op;
    logic [31:0] e_src_a;
    logic [31:0] e_src_b;
    logic        d_md_use;
    logic        start;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec;
    int n_err;
    logic [63:0] sb_q[$];
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    md_scheduler dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .e_md_op   (e_md_op),
        .e_src_a   (e_src_a),
        .e_src_b   (e_src_b),
        .d_md_use  (d_md_use),
        .start     (start),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] acc);
        int sa, sb, q, r;
        longint sp;
        logic [63:0] up;
        sa = a;
        sb = b;
        sp = longint'(sa) * longint'(sb);
        up = 64'(a) * 64'(b);
        case (op)
            MD_MULT:  return sp;
            MD_MULTU: return up;
            MD_DIV: begin
                if (b == 32'd0) return acc;
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            MD_DIVU: begin
                if (b == 32'd0) return acc;
                return {a % b, a / b};
            end
            default:  return acc;
        endcase
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic dmu, output int nbusy, output int nstall,
                         output logic st, output logic last_stall);
        @(negedge clk);
        e_md_op = op; e_src_a = a; e_src_b = b; d_md_use = dmu;
        #1;
        st = start;
        nstall = int'(stall_req);
        nbusy = 0;
        @(posedge clk);
        @(negedge clk);
        e_md_op = MD_NONE;
        #1;
        for (int i = 0; i < 40 && busy; i++) begin
            nbusy++;
            nstall += int'(stall_req);
            @(negedge clk);
            #1;
        end
        last_stall = stall_req;
        d_md_use = 1'b0;
    endtask

    task automatic check_commit(input string name);
        logic [63:0] e;
        n_vec++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: scoreboard empty, got hi=%h lo=%h", name, hi, lo);
        end else begin
            e = sb_q.pop_front();
            if ({hi, lo} !== e) begin
                n_err++;
                $display("FAIL %s: got hi=%h lo=%h, expected hi=%h lo=%h", name, hi, lo, e[63:32], e[31:0]);
            end
            exp_hi = e[63:32];
            exp_lo = e[31:0];
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int nexp);
        int nb, ns;
        logic st, ls;
        sb_q.push_back(model(op, a, b, {exp_hi, exp_lo}));
        issue(op, a, b, 1'b0, nb, ns, st, ls);
        n_vec++;
        if (nb !== nexp || st !== 1'b1 || ns !== 0) begin
            n_err++;
            $display("FAIL %s_busy: busy=%0d start=%b stall=%0d, expected busy=%0d start=1 stall=0", name, nb, st, ns, nexp);
        end
        check_commit(name);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; e_md_op = MD_NONE; e_src_a = 32'd0; e_src_b = 32'd0; d_md_use = 1'b0;
        repeat (2) @(negedge clk);
        e_md_op = MD_MULT; d_md_use = 1'b1;
        #1;
        n_vec++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || start !== 1'b1 || stall_req !== 1'b1) begin
            n_err++;
            $display("FAIL reset: busy=%b hi=%h lo=%h start=%b stall=%b, expected 0 0 0 1 1", busy, hi, lo, start, stall_req);
        end
        e_md_op = MD_NONE; d_md_use = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        exp_hi = 32'd0; exp_lo = 32'd0;
    endtask

    task automatic test_mult();
        run_op("mult", MD_MULT, 32'hFFFFFFFE, 32'd3, 5);
        run_op("multu", MD_MULTU, 32'hFFFFFFFE, 32'd3, 5);
    endtask

    task automatic test_div();
        run_op("div", MD_DIV, 32'hFFFFFFF9, 32'd2, 10);
        run_op("divu_zero", MD_DIVU, 32'd7, 32'd0, 10);
    endtask

    task automatic test_stall();
        int nb, ns;
        logic st, ls;
        sb_q.push_back(model(MD_MULT, 32'h00001234, 32'h00000010, {exp_hi, exp_lo}));
        issue(MD_MULT, 32'h00001234, 32'h00000010, 1'b1, nb, ns, st, ls);
        n_vec++;
        if (nb !== 5 || ns !== 6 || ls !== 1'b0) begin
            n_err++;
            $display("FAIL stall: busy=%0d stall_cycles=%0d last=%b, expected 5 6 0", nb, ns, ls);
        end
        check_commit("stall_mult");
    endtask

    task automatic test_mthi();
        int nb, ns;
        logic st, ls;
        issue(MD_MTHI, 32'h12345678, 32'd0, 1'b0, nb, ns, st, ls);
        exp_hi = 32'h12345678;
        n_vec++;
        if (hi !== exp_hi || lo !== exp_lo || nb !== 0 || st !== 1'b0) begin
            n_err++;
            $display("FAIL mthi: hi=%h lo=%h busy=%0d start=%b, expected %h %h 0 0", hi, lo, nb, st, exp_hi, exp_lo);
        end
        issue(MD_MTLO, 32'hCAFEF00D, 32'd0, 1'b0, nb, ns, st, ls);
        exp_lo = 32'hCAFEF00D;
        n_vec++;
        if (hi !== exp_hi || lo !== exp_lo || nb !== 0) begin
            n_err++;
            $display("FAIL mtlo: hi=%h lo=%h busy=%0d, expected %h %h 0", hi, lo, nb, exp_hi, exp_lo);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [3:0] op;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = 32'($urandom_range(1, 5000));
            if ($urandom_range(0, 1) == 1) b = 32'd0 - b;
            op = 4'($urandom_range(1, 4));
            run_op("random", op, a, b, (op == MD_DIV || op == MD_DIVU) ? 10 : 5);
        end
    endtask

    task automatic test_madd();
        int nb, ns;
        logic st, ls;
        issue(MD_MTHI, 32'd0, 32'd0, 1'b0, nb, ns, st, ls);
        issue(MD_MTLO, 32'hFFFFFFFF, 32'd0, 1'b0, nb, ns, st, ls);
        exp_hi = 32'd0; exp_lo = 32'hFFFFFFFF;
`ifdef MDU_MADD_EN
        sb_q.push_back(64'h00000001_00000000);
        issue(MD_MADDU, 32'd1, 32'd1, 1'b0, nb, ns, st, ls);
        n_vec++;
        if (nb !== 5 || st !== 1'b1) begin
            n_err++;
            $display("FAIL maddu_busy: busy=%0d start=%b, expected 5 1", nb, st);
        end
        check_commit("maddu");
`else
        issue(MD_MADDU, 32'd1, 32'd1, 1'b0, nb, ns, st, ls);
        n_vec++;
        if (nb !== 0 || st !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
            n_err++;
            $display("FAIL maddu_off: busy=%0d start=%b hi=%h lo=%h, expected 0 0 %h %h", nb, st, hi, lo, exp_hi, exp_lo);
        end
`endif
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        e_md_op = MD_DIV; e_src_a = 32'hFFFFFFF9; e_src_b = 32'd2;
        @(posedge clk);
        @(negedge clk);
        e_md_op = MD_NONE;
        repeat (2) @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_err++;
            $display("FAIL reset_mid: busy=%b hi=%h lo=%h, expected 0 0 0", busy, hi, lo);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_err++;
            $display("FAIL reset_no_commit: busy=%b hi=%h lo=%h, expected 0 0 0", busy, hi, lo);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_mult();
        test_div();
        test_stall();
        test_mthi();
        test_random();
        test_madd();
        test_mthi();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
